// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Parameter legality and latency are kept here so RTL and bench agree.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  function automatic bit bpc_legal(int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

  function automatic int div_latency(int width, int bpc);
    return width / bpc + 2;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dsr};

  // The partial remainder is below the divisor, so a borrow
  // always lands in the top bit of the WIDTH+1 difference.
  assign o_q   = ~w_diff[WIDTH];
  assign o_rem = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned restoring divider with flush,
// retiring BITS_PER_CYCLE quotient bits per cycle.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  if (!bpc_legal(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0 ||
      WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_cfg
    $error("iter_divider: illegal WIDTH/BITS_PER_CYCLE");
  end

  div_state_e r_state;
  div_state_e w_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH-1:0]          w_rem [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qb;
  logic                      w_dvd_neg;
  logic                      w_dsr_neg;
  logic [WIDTH-1:0]          w_rmag;

  assign w_rem[0] = r_rem;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (w_rem[k]),
      .i_bit (r_dvd[WIDTH-1-k]),
      .i_dsr (r_dsr),
      .o_rem (w_rem[k+1]),
      .o_q   (w_qb[BITS_PER_CYCLE-1-k])
    );
  end

  assign w_dvd_neg = r_sgn & r_dvd[WIDTH-1];
  assign w_dsr_neg = r_sgn & r_dsr[WIDTH-1];
  // r_dvd still holds the dividend magnitude when the divisor was zero
  assign w_rmag    = r_zero ? r_dvd : r_rem;

  always_comb begin
    w_nxt = r_state;
    if (flush) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: if (start) w_nxt = PREP;
        PREP:       w_nxt = (r_dsr == '0) ? FIX : CALC;
        CALC:       if (r_cnt == '0) w_nxt = FIX;
        FIX:        w_nxt = DONE;
        default:    w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else if (flush) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_dvd  <= dividend;
            r_dsr  <= divisor;
            r_sgn  <= signed_div;
          end
        end
        PREP: begin
          r_neg_r <= w_dvd_neg;
          r_neg_q <= w_dvd_neg ^ w_dsr_neg;
          // MIN negates to itself, which is its correct magnitude
          r_dvd   <= w_dvd_neg ? -r_dvd : r_dvd;
          r_dsr   <= w_dsr_neg ? -r_dsr : r_dsr;
          r_zero  <= (r_dsr == '0);
          r_rem   <= '0;
          r_cnt   <= CNT_INIT;
        end
        CALC: begin
          r_rem <= w_rem[BITS_PER_CYCLE];
          r_dvd <= {r_dvd[WIDTH-BITS_PER_CYCLE-1:0], w_qb};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_q    <= r_zero ? '1 : (r_neg_q ? -r_dvd : r_dvd);
          r_r    <= r_neg_r ? -w_rmag : w_rmag;
          r_done <= 1'b1;
          r_dbz  <= r_zero;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == PREP) || (r_state == CALC) ||
                       (r_state == FIX);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign quotient    = r_q;
  assign remainder   = r_r;

endmodule

// File: tb/tb_iter_divider.sv
// Bench: BPC=1 and BPC=4 dividers share stimulus; a scoreboard per
// instance is checked against a plain-arithmetic reference model.
module tb_iter_divider;
  import div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;

  logic         busy_o [2];
  logic         done_o [2];
  logic         dbz_o  [2];
  logic [W-1:0] q_o    [2];
  logic [W-1:0] r_o    [2];
  logic         pdone  [2] = '{1'b0, 1'b0};

  exp_t sb0[$];
  exp_t sb1[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy_o[0]), .done(done_o[0]), .div_by_zero(dbz_o[0]),
    .quotient(q_o[0]), .remainder(r_o[0])
  );

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy_o[1]), .done(done_o[1]), .div_by_zero(dbz_o[1]),
    .quotient(q_o[1]), .remainder(r_o[1])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Truncating division done in 64-bit arithmetic; MIN/-1 needs no care.
  function automatic exp_t model(bit sg, logic [W-1:0] a,
                                 logic [W-1:0] b, int bpc, int t0);
    exp_t e;
    longint sa, sb;
    e.t0 = t0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      e.lat = 2;
    end else begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
      e.z = 1'b0;
      e.lat = div_latency(W, bpc);
    end
    return e;
  endfunction

  task automatic check_dut(input int k);
    exp_t e;
    bit have;
    have = 1'b0;
    if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
    if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
    chk($sformatf("dut%0d_expected_pending", k), 64'(have), 64'd1);
    if (have) begin
      chk($sformatf("dut%0d_quotient", k), 64'(q_o[k]), 64'(e.q));
      chk($sformatf("dut%0d_remainder", k), 64'(r_o[k]), 64'(e.r));
      chk($sformatf("dut%0d_div_by_zero", k), 64'(dbz_o[k]), 64'(e.z));
      chk($sformatf("dut%0d_latency", k), 64'(cyc - e.t0), 64'(e.lat));
      chk($sformatf("dut%0d_busy_at_done", k), 64'(busy_o[k]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && done_o[k] && !pdone[k]) check_dut(k);
      pdone[k] <= done_o[k];
    end
  end

  task automatic issue(input bit sg, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    sb0.push_back(model(sg, a, b, 1, cyc + 1));
    sb1.push_back(model(sg, a, b, 4, cyc + 1));
    signed_div = sg;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    signed_div = $urandom_range(0, 1);
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done_o[0] && done_o[1]) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 64'(done_o[0] && done_o[1]), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 255));
      5: v = -32'($urandom_range(1, 255));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic dir(input bit sg, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    issue(sg, a, b);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    bit sg;
    #13;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), 64'(busy_o[k]), 64'd0);
      chk($sformatf("rst_done%0d", k), 64'(done_o[k]), 64'd0);
      chk($sformatf("rst_dbz%0d", k), 64'(dbz_o[k]), 64'd0);
      chk($sformatf("rst_q%0d", k), 64'(q_o[k]), 64'd0);
      chk($sformatf("rst_r%0d", k), 64'(r_o[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir(0, 32'h0000_0200, 32'h0000_0100);
    dir(0, 32'hFFFF_FFFF, 32'd1);
    dir(0, 32'h8000_0001, 32'd2);
    dir(1, -32'h200, 32'h100);
    dir(1, -32'd7, 32'd2);
    dir(1, 32'd7, -32'd2);
    dir(1, 32'h8000_0000, 32'hFFFF_FFFF);
    dir(0, 32'h8000_0000, 32'hFFFF_FFFF);
    dir(0, 32'd5, 32'd0);
    dir(1, 32'd5, 32'd0);
    dir(1, -32'd5, 32'd0);

    issue(0, 32'd1000, 32'd3);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush_busy%0d", k), 64'(busy_o[k]), 64'd0);
      chk($sformatf("flush_done%0d", k), 64'(done_o[k]), 64'd0);
    end
    dir(0, 32'd100, 32'd7);

    flush = 1'b1;
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flushstart_busy%0d", k), 64'(busy_o[k]), 64'd0);
      chk($sformatf("flushstart_done%0d", k), 64'(done_o[k]), 64'd0);
      chk($sformatf("flush_keep_q%0d", k), 64'(q_o[k]), 64'd14);
      chk($sformatf("flush_keep_r%0d", k), 64'(r_o[k]), 64'd2);
    end

    issue(1, 32'd12345, 32'd7);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_busy%0d", k), 64'(busy_o[k]), 64'd0);
      chk($sformatf("arst_done%0d", k), 64'(done_o[k]), 64'd0);
      chk($sformatf("arst_q%0d", k), 64'(q_o[k]), 64'd0);
      chk($sformatf("arst_r%0d", k), 64'(r_o[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 800; i++) begin
      sg = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      issue(sg, a, b);
      if (i % 5 == 0 && b != '0) begin
        repeat (2) @(negedge clk);
        signed_div = ~sg;
        dividend = $urandom;
        divisor = 32'($urandom_range(1, 9));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
